// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-to-decode output stage: one fetched word with its byte address,
// moved across a valid/ready handshake.
interface instr_fetch_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads async instruction memory
// and registers each word into a one-entry valid/ready stage for decode.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_rdata,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    instr_fetch_ctrl_if.master        dec,
    output logic                      fault,
    output logic [31:0]               fault_pc
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_FETCH,
        ST_FAULT
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        vld_q;
    logic [31:0] instr_q;
    logic [31:0] opc_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;

    logic        take;
    logic        slot_free;
    logic        pc_bad;
    logic [32:0] pc_lim;

    assign take      = vld_q & dec.out_ready;
    assign slot_free = ~vld_q | take;
    assign pc_d      = pc_q + 32'd4;

    // 33-bit compare so a PC near 2^32 cannot wrap past the limit
    assign pc_lim = 33'(IMEM_BYTES) - 33'd4;
    assign pc_bad = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} > pc_lim);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            pc_q       <= RESET_PC;
            vld_q      <= 1'b0;
            instr_q    <= 32'd0;
            opc_q      <= 32'd0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    if (redirect_valid) begin
                        pc_q  <= redirect_pc;
                        vld_q <= 1'b0;
                    end else if (take) begin
                        vld_q <= 1'b0;
                    end
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!run) state_q <= ST_STOP;
                    if (redirect_valid) begin
                        pc_q  <= redirect_pc;
                        vld_q <= 1'b0;
                    end else if (!run || !slot_free) begin
                        if (take) vld_q <= 1'b0;
                    end else if (pc_bad) begin
                        state_q    <= ST_FAULT;
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                        vld_q      <= 1'b0;
                    end else begin
                        instr_q <= imem_rdata;
                        opc_q   <= pc_q;
                        vld_q   <= 1'b1;
                        pc_q    <= pc_d;
                    end
                end
                ST_FAULT: begin
                    vld_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_FAULT;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr     = pc_q;
    assign dec.out_valid = vld_q;
    assign dec.out_instr = instr_q;
    assign dec.out_pc    = opc_q;
    assign fault         = fault_q;
    assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed scenarios then random
// run/ready/redirect/reset traffic against a word-level reference model.
module tb_instr_fetch_ctrl;

    localparam int unsigned NB = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [31:0] fault_pc;

    instr_fetch_ctrl_if ifc ();

    instr_fetch_ctrl #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (NB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (ifc.master),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] W [0:NB/4-1];
    logic [7:0]  mem [0:NB-1];

    always_comb begin
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_addr <= NB - 4)
            imem_rdata = {mem[imem_addr+3], mem[imem_addr+2],
                          mem[imem_addr+1], mem[imem_addr]};
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // reference model: word-level view of what fetch should be doing
    logic [31:0] m_pc      = 32'h0;
    bit          m_enabled = 0;
    bit          m_faulted = 0;
    bit          m_hv      = 0;
    logic [31:0] m_fpc     = 32'h0;
    logic [63:0] exp_q [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_enabled = 0; m_faulted = 0;
            m_hv = 0; m_fpc = 32'h0; exp_q.delete();
        end else if (!m_faulted) begin
            if (m_hv && ifc.out_ready && !redirect_valid) m_hv = 0;
            if (redirect_valid) begin
                m_pc = redirect_pc; m_hv = 0; exp_q.delete();
            end else if (m_enabled && run && !m_hv) begin
                if (m_pc % 4 != 0 || longint'(m_pc) + 4 > NB) begin
                    m_faulted = 1; m_fpc = m_pc;
                end else begin
                    exp_q.push_back({m_pc, W[m_pc/4]});
                    m_hv = 1;
                    m_pc = m_pc + 4;
                end
            end
            m_enabled = run;
        end
    end

    // monitor: consume accepted words, compare visible state to the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(ifc.out_valid), 32'(m_hv));
            chk("fault", 32'(fault), 32'(m_faulted));
            chk("fault_pc", fault_pc, m_fpc);
            chk("imem_addr", imem_addr, m_pc);
            if (rst_n && ifc.out_valid && ifc.out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_accept", 32'(ifc.out_valid), 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("acc_pc", ifc.out_pc, e[63:32]);
                    chk("acc_instr", ifc.out_instr, e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0;
        step(); step();
    endtask

    int k;
    int r;

    initial begin
        for (int i = 0; i < NB / 4; i++) begin
            W[i] = $urandom;
            for (int b = 0; b < 4; b++) mem[4*i+b] = W[i][8*b +: 8];
        end
        rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; ifc.out_ready = 1'b0;
        step();
        mon_en = 1;
        step();
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);

        // sequential fetch and first-word latency
        rst_n = 1'b1; run = 1'b1; ifc.out_ready = 1'b1;
        k = 0;
        while (!ifc.out_valid && k < 10) begin step(); k++; end
        chk("latency", 32'(k), 32'd2);
        chk("w0_pc", ifc.out_pc, 32'd0);
        chk("w0", ifc.out_instr, W[0]);
        step();
        chk("w1_pc", ifc.out_pc, 32'd4);

        // backpressure on the word at 4
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", ifc.out_pc, 32'd4);
            chk("stall_instr", ifc.out_instr, W[1]);
            chk("stall_addr", imem_addr, 32'd8);
        end
        ifc.out_ready = 1'b1;
        step();
        chk("post_stall_pc", ifc.out_pc, 32'd8);
        chk("post_stall_instr", ifc.out_instr, W[2]);

        // redirect flushes the valid word
        redirect_valid = 1'b1; redirect_pc = 32'd16;
        step();
        redirect_valid = 1'b0;
        chk("redir_flush", 32'(ifc.out_valid), 32'd0);
        step();
        chk("redir_pc", ifc.out_pc, 32'd16);
        chk("redir_instr", ifc.out_instr, W[4]);

        // run off the end of memory
        k = 0;
        while (!fault && k < 12) begin step(); k++; end
        chk("range_fault", 32'(fault), 32'd1);
        chk("range_fault_pc", fault_pc, 32'd32);
        chk("range_last_pc", ifc.out_pc, 32'd28);

        // misaligned redirect is sticky
        do_reset();
        rst_n = 1'b1; run = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'd6;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'd6);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        step();
        redirect_valid = 1'b0;
        step(); step();
        chk("mis_sticky", 32'(fault), 32'd1);
        chk("mis_pc_frozen", imem_addr, 32'd6);
        chk("mis_no_valid", 32'(ifc.out_valid), 32'd0);

        // run drop while holding a word, then drain
        do_reset();
        rst_n = 1'b1; run = 1'b1; ifc.out_ready = 1'b1;
        step(); step(); step();
        ifc.out_ready = 1'b0; run = 1'b0;
        step(); step();
        chk("stop_hold_pc", ifc.out_pc, 32'd4);
        chk("stop_addr", imem_addr, 32'd8);
        ifc.out_ready = 1'b1;
        step(); step();
        chk("stop_drained", 32'(ifc.out_valid), 32'd0);
        chk("stop_addr2", imem_addr, 32'd8);

        // reset in the middle of a stall with a pending redirect
        run = 1'b1; ifc.out_ready = 1'b0;
        step(); step(); step();
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd12;
        step();
        chk("rst_mid_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_mid_pc", imem_addr, 32'h0);
        rst_n = 1'b1; redirect_valid = 1'b0; run = 1'b0;
        step(); step();
        chk("rst_mid_stop", 32'(ifc.out_valid), 32'd0);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            run = ($urandom_range(0, 9) != 0);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 15);
            if (r == 0) redirect_pc = 32'(4 * $urandom_range(0, 7) + 2);
            else        redirect_pc = 32'(4 * $urandom_range(0, 8));
            rst_n = !(m_faulted && $urandom_range(0, 3) == 0)
                    && ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; redirect_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the byte-addressed, little-endian, asynchronous-read instruction memory (word = bytes PC+3..PC, 32-byte default depth).
- Owns the program counter, drives the memory address, and registers each fetched word into a one-entry output stage with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute and flags misaligned or out-of-range fetches as a sticky fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 32, instruction memory depth in bytes; a word fetch is legal only when pc+3 < IMEM_BYTES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- run  input  1  fetch enable; 0 stops issuing new fetches.
- imem_addr  output  32  byte address to instruction memory; equals pc register (combinational from register).
- imem_rdata  input  32  instruction word returned combinationally by memory for imem_addr.
- redirect_valid  input  1  execute requests PC change this cycle.
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  out_instr/out_pc hold a valid fetched word.
- out_ready  input  1  decode accepts the word when out_valid & out_ready.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte address of out_instr.
- fault  output  1  sticky fetch fault.
- fault_pc  output  32  address that caused the fault.

Behaviour:
- Reset is synchronous, active-low, applied at a clk edge where rst_n=0.
- Reset values: pc=RESET_PC, state=STOP, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
- States: STOP, FETCH, FAULT.
  - STOP: out_valid still drains (cleared on handshake). Go to FETCH when run=1. No fetch is issued in the transition cycle.
  - FETCH: go to STOP when run=0 (the fetch decision that cycle is suppressed). Go to FAULT on a fault condition.
  - FAULT: terminal until reset. out_valid forced 0, pc frozen, redirects ignored, fault=1.
- Slot free = (out_valid==0) or (out_valid & out_ready).
- Fetch in FETCH (no redirect, slot free, pc legal):
  - At the edge: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - Latency: one cycle from address to out_valid.
  - Sustained throughput: one word per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 → out_instr, out_pc, out_valid and pc all hold.
- Redirect has priority over fetch and over stall, in any state except FAULT:
  - At the edge: pc<=redirect_pc, out_valid<=0 (the held or in-flight word is flushed even if out_ready=1 that cycle; decode must not consume it).
  - No fetch that cycle; first post-redirect word is valid two edges after redirect assertion.
  - In STOP, the redirect updates pc only.
- Fault conditions, checked only when a fetch would otherwise occur:
  - pc[1:0]!=0, or
  - pc > IMEM_BYTES-4, computed in 33-bit arithmetic so there is no wrap.
  - On fault: FAULT state, fault<=1, fault_pc<=pc, out_valid<=0, no capture.
- Redirect target legality is checked on the subsequent fetch, not at redirect time.
- PC arithmetic is 32-bit. pc+4 cannot wrap in practice because the range check faults first.
- Simultaneous redirect_valid and run=0 in FETCH: pc<=redirect_pc, out_valid<=0, state→STOP.
- Reset mid-operation overrides everything, including a pending handshake or redirect.

Test Plan:
- Reset, then run=1, out_ready=1, memory holding words W0..W3 at 0,4,8,12:
  - out_valid first asserts 2 edges after rst_n rises.
  - Then (out_pc, out_instr) = (0,W0), (4,W1), (8,W2), (12,W3) on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4:
  - out_instr=W1 and out_pc=4 stable; imem_addr=8 stable.
  - After out_ready=1: next word (8,W2) on the following cycle, no duplicate or skip.
- Redirect with out_valid=1, out_ready=1, redirect_pc=16:
  - Next cycle out_valid=0.
  - Following cycle out_pc=16, out_instr=W4.
  - The flushed word is never counted as accepted.
- Misaligned redirect to 0x6:
  - Next edge fault=1, fault_pc=6, out_valid=0 from then on.
  - Subsequent redirect to 0 ignored; only rst_n=0 clears it.
- Range fault, IMEM_BYTES=32, sequential fetch:
  - pc=28 fetches normally.
  - pc=32 raises fault=1, fault_pc=32.
- run toggle and reset mid-stall:
  - run=0 at pc=8 → no new captures, held word drains on out_ready.
  - rst_n=0 during a stall → next cycle out_valid=0, pc=RESET_PC, state STOP.
